// File: rtl/handshake_constant_stream.sv
`default_nettype none
// ============================================================================
// Module   : handshake_constant_stream
// Brief    : One data token per control token: constant or wrapping affine
//            sequence, with optional one-entry output slot.
// Revision : 1.0
// ============================================================================
module handshake_constant_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BASE       = 0,
  parameter int unsigned STRIDE     = 0,
  parameter int unsigned COUNT      = 0,
  parameter bit          OUT_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam logic [DATA_WIDTH-1:0] BASE_T   = DATA_WIDTH'(BASE);
  localparam logic [DATA_WIDTH-1:0] STRIDE_T = DATA_WIDTH'(STRIDE);
  localparam logic [31:0]           LAST_IDX = 32'(COUNT - 1);

  logic [31:0]           idx;
  logic [DATA_WIDTH-1:0] cur;
  logic                  emit_last;
  logic                  xfer;

  assign emit_last = (COUNT != 0) && (idx == LAST_IDX);
  assign xfer      = ctrl_valid && ctrl_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cur <= BASE_T;
    end else if (xfer) begin
      if (emit_last) begin
        idx <= '0;
        cur <= BASE_T;
      end else begin
        idx <= idx + 32'd1;
        cur <= cur + STRIDE_T;
      end
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic                  full;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  last_q;

      // A full slot may refill in the same cycle it drains.
      assign ctrl_ready = !rst && (!full || outs_ready);
      assign outs       = data_q;
      assign outs_last  = last_q;
      assign outs_valid = full;

      always_ff @(posedge clk) begin
        if (rst) begin
          full   <= 1'b0;
          data_q <= '0;
          last_q <= 1'b0;
        end else if (xfer) begin
          full   <= 1'b1;
          data_q <= cur;
          last_q <= emit_last;
        end else if (full && outs_ready) begin
          full <= 1'b0;
        end
      end
    end else begin : g_pass
      assign ctrl_ready = !rst && outs_ready;
      assign outs       = cur;
      assign outs_last  = emit_last;
      assign outs_valid = !rst && ctrl_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/handshake_constant_stream.md
# handshake_constant_stream

Parametrised constant/sequence source for the dataflow handshake fabric. Each token consumed on the control channel produces one data token on the output channel. The value is either a fixed constant (STRIDE = 0) or an affine sequence BASE, BASE+STRIDE, … that wraps every COUNT tokens. An optional output register breaks the combinational valid/ready path between control and consumer. The block drops in wherever a plain constant node sits today, and it additionally serves loop-index and address-pattern generation.

## Interface
- DATA_WIDTH, 32, width of `outs`
- BASE, 0, first value emitted after reset and after every wrap; truncated to DATA_WIDTH
- STRIDE, 0, increment added per emitted token; truncated to DATA_WIDTH; arithmetic is modulo 2^DATA_WIDTH
- COUNT, 0, sequence period in tokens; 0 means never wrap; otherwise 1..2^32-1
- OUT_REG, 1, 1 = registered output slot; 0 = combinational pass-through
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- ctrl_valid  in  1  control token present
- ctrl_ready  out  1  block accepts control token
- outs  out  DATA_WIDTH  emitted value
- outs_last  out  1  high with the token that is the final element (index COUNT-1) of a period; always 0 when COUNT = 0
- outs_valid  out  1  output token present
- outs_ready  in  1  consumer accepts output token

## Operation
- Internal state:
  - `idx`: 32-bit period index.
  - `cur`: DATA_WIDTH-bit next value.
  - With OUT_REG = 1 only: output slot `full`, `data_q`, `last_q`.
- A control transfer is `ctrl_valid && ctrl_ready` in a cycle. Exactly one sequence step occurs per control transfer, and no step occurs otherwise.
- Step rule:
  - Emitted value = `cur`.
  - Emitted last = (COUNT != 0 && idx == COUNT-1).
  - If emitted last: `idx` ← 0 and `cur` ← BASE.
  - Otherwise: `idx` ← idx+1 and `cur` ← cur+STRIDE, wrapping mod 2^DATA_WIDTH.
- When COUNT = 0, `idx` is not used for wrapping. It may saturate or wrap freely and has no observable effect.
- OUT_REG = 0:
  - `outs` = cur, `outs_last` = emitted last, `outs_valid` = ctrl_valid, `ctrl_ready` = outs_ready.
  - The control transfer and output transfer occur in the same cycle.
- OUT_REG = 1 (one-entry pipeline slot, full throughput):
  - `ctrl_ready` = !full || outs_ready.
  - On a control transfer: `data_q` ← cur, `last_q` ← emitted last, `full` ← 1.
  - Else if `full && outs_ready`: `full` ← 0.
  - `outs` = data_q, `outs_last` = last_q, `outs_valid` = full.
  - The slot contents are held stable while `full && !outs_ready`.
- STRIDE = 0 with COUNT = 0 degenerates to a pure constant source emitting BASE forever.

## Timing
- Reset (rst high at a rising edge), all modes: `idx` = 0, `cur` = BASE.
- Reset, OUT_REG = 1: additionally `full` = 0, `data_q` = 0, `last_q` = 0.
- Outputs while rst is high:
  - `ctrl_ready` is forced to 0, so no token is accepted in a reset cycle.
  - OUT_REG = 1: `outs_valid` = 0 from the cycle after reset is sampled.
  - OUT_REG = 0: `outs_valid` is forced to 0 while rst is high.
- Reset asserted mid-sequence or with the slot full discards the pending token and restarts at BASE. No token is emitted for the discarded entry.
- Latency:
  - OUT_REG = 0: 0 cycles.
  - OUT_REG = 1: 1 cycle from control transfer to `outs_valid`.
- Throughput is 1 token/cycle in both modes when outs_ready is held high.
- Backpressure, OUT_REG = 1:
  - With `full` and `!outs_ready`, `ctrl_ready` = 0, and `outs`/`outs_last` must not change.
  - A simultaneous drain and fill (`full`, `outs_ready`, `ctrl_valid`) keeps `full` = 1 and loads the new value.
- Wrap boundary: the token with idx = COUNT-1 carries outs_last = 1. The next token carries BASE, with no bubble.
- COUNT = 1: every token is BASE with outs_last = 1.
- Data arithmetic overflow wraps silently. For example, DATA_WIDTH = 8, BASE = 250, STRIDE = 4 emits 250, 254, 2, 6.

## Test plan
- OUT_REG=1, DATA_WIDTH=8, BASE=0x44, STRIDE=0, COUNT=0, 10 back-to-back ctrl tokens with outs_ready=1 -> ten tokens of 0x44, outs_last always 0, first outs_valid 1 cycle after first transfer, no bubbles.
- OUT_REG=1, DATA_WIDTH=16, BASE=10, STRIDE=3, COUNT=4, 9 tokens with outs_ready=1 -> 10, 13, 16, 19(last), 10, 13, 16, 19(last), 10.
- OUT_REG=1, same parameters, random outs_ready (about 50% low) with ctrl_valid always high -> the same ordered sequence with none lost or duplicated; outs stable while valid and !ready; ctrl_ready=0 exactly when full and !outs_ready.
- OUT_REG=0, DATA_WIDTH=8, BASE=250, STRIDE=4, COUNT=0, outs_ready toggled every cycle -> outs_valid mirrors ctrl_valid combinationally; accepted values are 250, 254, 2, 6.
- OUT_REG=1, BASE=5, STRIDE=1, COUNT=8: emit 3 tokens, hold outs_ready=0 so the slot is full, then assert rst for 1 cycle -> outs_valid=0 after reset; next tokens are 5, 6, 7, and ctrl_ready=0 during the reset cycle.
- OUT_REG=1, COUNT=1, BASE=7, STRIDE=9, 3 tokens -> 7, 7, 7, each with outs_last=1.
